// File: rtl/data_cache.sv
// Direct-mapped, write-back, write-allocate data cache: 8 blocks x 4 bytes,
// 8-bit byte address, single-block refill and writeback over a busywait handshake.
module data_cache (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        READ,
    input  logic        WRITE,
    input  logic [7:0]  ADDRESS,
    input  logic [7:0]  WRITEDATA,
    output logic [7:0]  READDATA,
    output logic        BUSYWAIT,
    output logic        MEM_READ,
    output logic        MEM_WRITE,
    output logic [5:0]  MEM_ADDRESS,
    output logic [31:0] MEM_WRITEDATA,
    input  logic [31:0] MEM_READDATA,
    input  logic        MEM_BUSYWAIT
);

    typedef enum logic [1:0] {
        IDLE,
        WRITEBACK,
        FETCH
    } state_t;

    state_t      state;
    logic [7:0]  valid;
    logic [7:0]  dirty;
    logic [2:0]  tags   [8];
    logic [31:0] blocks [8];

    logic [2:0]  tag_in;
    logic [2:0]  idx;
    logic [1:0]  offset;
    logic        hit;
    logic        req;
    logic        write_hit;
    logic        fill;

    assign tag_in = ADDRESS[7:5];
    assign idx    = ADDRESS[4:2];
    assign offset = ADDRESS[1:0];

    assign hit       = valid[idx] && (tags[idx] == tag_in);
    assign req       = READ | WRITE;
    assign write_hit = (state == IDLE) && WRITE && hit;
    assign fill      = (state == FETCH) && !MEM_BUSYWAIT;

    // NOTE: BUSYWAIT is a combinational decode so a hit costs zero stall cycles.
    assign BUSYWAIT = !RESET && req && !((state == IDLE) && hit);

    assign READDATA      = blocks[idx][{offset, 3'b000} +: 8];
    assign MEM_WRITEDATA = blocks[idx];
    assign MEM_ADDRESS   = (state == WRITEBACK) ? {tags[idx], idx} : {tag_in, idx};

    // Control FSM; memory requests are registered alongside the state.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state     <= IDLE;
            valid     <= '0;
            dirty     <= '0;
            MEM_READ  <= 1'b0;
            MEM_WRITE <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req && !hit) begin
                        if (valid[idx] && dirty[idx]) begin
                            state     <= WRITEBACK;
                            MEM_WRITE <= 1'b1;
                        end else begin
                            state    <= FETCH;
                            MEM_READ <= 1'b1;
                        end
                    end else if (write_hit) begin
                        dirty[idx] <= 1'b1;
                    end
                end
                WRITEBACK: begin
                    if (!MEM_BUSYWAIT) begin
                        state     <= FETCH;
                        MEM_WRITE <= 1'b0;
                        MEM_READ  <= 1'b1;
                    end
                end
                FETCH: begin
                    if (!MEM_BUSYWAIT) begin
                        state      <= IDLE;
                        MEM_READ   <= 1'b0;
                        valid[idx] <= 1'b1;
                        dirty[idx] <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    MEM_READ  <= 1'b0;
                    MEM_WRITE <= 1'b0;
                end
            endcase
        end
    end

    // NOTE: tag and data arrays carry no reset; the valid bits gate every use of them.
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            if (fill) begin
                blocks[idx] <= MEM_READDATA;
                tags[idx]   <= tag_in;
            end else if (write_hit) begin
                blocks[idx][{offset, 3'b000} +: 8] <= WRITEDATA;
            end
        end
    end

endmodule

// File: tb/tb_data_cache.sv
// Self-checking bench for data_cache: directed vector table, reset-mid-fetch
// sequence, and randomized accesses against a flat-memory reference model.
module tb_data_cache;

    logic        clk;
    logic        reset;
    logic        read;
    logic        write;
    logic [7:0]  address;
    logic [7:0]  writedata;
    logic [7:0]  readdata;
    logic        busywait;
    logic        mem_read;
    logic        mem_write;
    logic [5:0]  mem_address;
    logic [31:0] mem_writedata;
    logic [31:0] mem_readdata;
    logic        mem_busywait;

    data_cache dut (
        .CLK          (clk),
        .RESET        (reset),
        .READ         (read),
        .WRITE        (write),
        .ADDRESS      (address),
        .WRITEDATA    (writedata),
        .READDATA     (readdata),
        .BUSYWAIT     (busywait),
        .MEM_READ     (mem_read),
        .MEM_WRITE    (mem_write),
        .MEM_ADDRESS  (mem_address),
        .MEM_WRITEDATA(mem_writedata),
        .MEM_READDATA (mem_readdata),
        .MEM_BUSYWAIT (mem_busywait)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;
    int both_hi = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Initial memory image as bytes: block 0 is AA BB CC DD, everything else addr ^ 0x3C.
    function automatic logic [7:0] flat_init(input int a);
        logic [31:0] b0;
        b0 = 32'hDDCCBBAA;
        if (a < 4) return b0[8*a +: 8];
        return 8'(a) ^ 8'h3C;
    endfunction

    function automatic logic [31:0] init_word(input int blk);
        return {flat_init(4*blk+3), flat_init(4*blk+2), flat_init(4*blk+1), flat_init(4*blk)};
    endfunction

    // Block memory with programmable latency: busy for lat edges, completes on the next.
    logic [31:0] backing [64];
    int          cnt;
    int          lat_rd = 5;
    int          lat_wr = 3;
    logic        init_mem = 1'b0;
    logic        mreq;

    assign mreq         = mem_read | mem_write;
    assign mem_busywait = mreq && (cnt < (mem_write ? lat_wr : lat_rd));
    assign mem_readdata = backing[mem_address];

    always @(posedge clk) begin
        if (init_mem) begin
            for (int i = 0; i < 64; i++) backing[i] <= init_word(i);
            cnt <= 0;
        end else if (mreq) begin
            if (mem_busywait) cnt <= cnt + 1;
            else begin
                cnt <= 0;
                if (mem_write) backing[mem_address] <= mem_writedata;
            end
        end else begin
            cnt <= 0;
        end
    end

    // One CPU access held until BUSYWAIT drops; counts stall cycles and memory traffic.
    task automatic access(input logic rd, input logic wr, input logic [7:0] a, input logic [7:0] wd,
                          output int stalls, output logic [7:0] rdata, output int nrd, output int nwr,
                          output logic [5:0] rd_a, output logic [5:0] wr_a, output logic [31:0] wr_d);
        bit done;
        read = rd; write = wr; address = a; writedata = wd;
        stalls = 0; nrd = 0; nwr = 0; rd_a = '0; wr_a = '0; wr_d = '0; rdata = '0;
        done = 1'b0;
        while (!done) begin
            @(negedge clk);
            if (mem_read)  begin nrd++; rd_a = mem_address; end
            if (mem_write) begin nwr++; wr_a = mem_address; wr_d = mem_writedata; end
            if (mem_read && mem_write) both_hi++;
            if (!busywait) begin
                rdata = readdata;
                done  = 1'b1;
            end else begin
                stalls++;
                if (stalls > 500) begin
                    check("busywait_timeout", stalls, 0);
                    done = 1'b1;
                end
            end
        end
        @(posedge clk);
        #1;
        read = 1'b0; write = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1; init_mem = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0; init_mem = 1'b0;
    endtask

    typedef struct {
        logic        rd;
        logic        wr;
        logic [7:0]  addr;
        logic [7:0]  wdata;
        int          stall;
        logic        chk_rd;
        logic [7:0]  rdata;
        int          nrd;
        int          nwr;
        logic [5:0]  rd_a;
        logic [5:0]  wr_a;
        logic [31:0] wr_d;
    } vec_t;

    vec_t        vecs [12];
    logic [7:0]  flat [256];
    bit          mv [8];
    bit          md [8];
    logic [2:0]  mt [8];

    initial begin
        int          st, nr, nw, bad;
        logic [7:0]  rdv;
        logic [5:0]  ra, wa;
        logic [31:0] wdv;

        //          rd wr addr   wdata stall chk rdata  nrd nwr rd_a   wr_a   wr_d
        vecs[0]  = '{1, 0, 8'h00, 8'h00, 7,  1, 8'hAA, 6, 0, 6'h00, 6'h00, 32'h0};
        vecs[1]  = '{1, 0, 8'h03, 8'h00, 0,  1, 8'hDD, 0, 0, 6'h00, 6'h00, 32'h0};
        vecs[2]  = '{0, 1, 8'h01, 8'h5A, 0,  0, 8'h00, 0, 0, 6'h00, 6'h00, 32'h0};
        vecs[3]  = '{1, 0, 8'h01, 8'h00, 0,  1, 8'h5A, 0, 0, 6'h00, 6'h00, 32'h0};
        vecs[4]  = '{1, 0, 8'h20, 8'h00, 11, 1, 8'h1C, 6, 4, 6'h08, 6'h00, 32'hDDCC5AAA};
        vecs[5]  = '{0, 1, 8'h45, 8'h77, 7,  0, 8'h00, 6, 0, 6'h11, 6'h00, 32'h0};
        vecs[6]  = '{1, 0, 8'h45, 8'h00, 0,  1, 8'h77, 0, 0, 6'h00, 6'h00, 32'h0};
        vecs[7]  = '{1, 0, 8'h00, 8'h00, 7,  1, 8'hAA, 6, 0, 6'h00, 6'h00, 32'h0};
        vecs[8]  = '{1, 0, 8'h01, 8'h00, 0,  1, 8'h5A, 0, 0, 6'h00, 6'h00, 32'h0};
        vecs[9]  = '{1, 1, 8'h02, 8'h11, 0,  0, 8'h00, 0, 0, 6'h00, 6'h00, 32'h0};
        vecs[10] = '{1, 0, 8'h02, 8'h00, 0,  1, 8'h11, 0, 0, 6'h00, 6'h00, 32'h0};
        vecs[11] = '{1, 0, 8'h25, 8'h00, 11, 1, 8'h19, 6, 4, 6'h09, 6'h11, 32'h7B7A7778};

        // Reset: BUSYWAIT held low even with a pending request, no memory traffic after.
        reset = 1'b1; init_mem = 1'b1; read = 1'b1; write = 1'b0;
        address = 8'h00; writedata = 8'h00;
        @(negedge clk);
        check("busywait_in_reset", busywait, 0);
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b0; init_mem = 1'b0; read = 1'b0;
        @(negedge clk);
        check("reset_busywait", busywait, 0);
        check("reset_mem_read", mem_read, 0);
        check("reset_mem_write", mem_write, 0);
        @(posedge clk); #1;

        // Directed vectors: cold read, write hit, dirty eviction, write miss, read+write.
        lat_rd = 5; lat_wr = 3;
        for (int i = 0; i < 12; i++) begin
            access(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata, st, rdv, nr, nw, ra, wa, wdv);
            check($sformatf("v%0d_stall", i), st, vecs[i].stall);
            if (vecs[i].chk_rd) check($sformatf("v%0d_rdata", i), rdv, vecs[i].rdata);
            check($sformatf("v%0d_mem_read_cycles", i), nr, vecs[i].nrd);
            check($sformatf("v%0d_mem_write_cycles", i), nw, vecs[i].nwr);
            if (vecs[i].nrd != 0) check($sformatf("v%0d_fetch_addr", i), ra, vecs[i].rd_a);
            if (vecs[i].nwr != 0) begin
                check($sformatf("v%0d_wb_addr", i), wa, vecs[i].wr_a);
                check($sformatf("v%0d_wb_data", i), wdv, vecs[i].wr_d);
            end
        end

        // Reset in the middle of a long FETCH abandons it; the line stays invalid.
        lat_rd = 20;
        read = 1'b1; address = 8'h30;
        repeat (3) @(negedge clk);
        check("midfetch_mem_read", mem_read, 1);
        check("midfetch_addr", mem_address, 6'h0C);
        check("midfetch_busywait", busywait, 1);
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        check("midfetch_busywait_reset", busywait, 0);
        @(posedge clk);
        @(negedge clk);
        check("after_reset_mem_read", mem_read, 0);
        check("after_reset_busywait", busywait, 0);
        @(posedge clk); #1;
        reset = 1'b0; read = 1'b0;
        access(1, 0, 8'h30, 8'h00, st, rdv, nr, nw, ra, wa, wdv);
        check("refetch_stall", st, 22);
        check("refetch_rdata", rdv, 8'h0C);
        lat_rd = 2;
        access(1, 0, 8'h25, 8'h00, st, rdv, nr, nw, ra, wa, wdv);
        check("post_reset_miss_stall", st, 4);
        check("post_reset_no_wb", nw, 0);

        // Randomized accesses against a flat 256-byte memory plus per-index tag model.
        do_reset();
        for (int a = 0; a < 256; a++) flat[a] = flat_init(a);
        for (int i = 0; i < 8; i++) begin mv[i] = 0; md[i] = 0; mt[i] = '0; end
        for (int n = 0; n < 300; n++) begin
            logic       rd, wr, h;
            logic [7:0] a, wd;
            logic [2:0] ix, tg;
            int         exp_st, exp_wb;
            lat_rd = $urandom_range(0, 4);
            lat_wr = $urandom_range(0, 4);
            a  = {3'($urandom_range(0, 2)), 5'($urandom_range(0, 31))};
            wd = 8'($urandom);
            rd = 1'($urandom_range(0, 1));
            wr = 1'($urandom_range(0, 1));
            if (!rd && !wr) rd = 1'b1;
            ix = a[4:2]; tg = a[7:5];
            h  = mv[ix] && (mt[ix] == tg);
            exp_wb = (!h && mv[ix] && md[ix]) ? lat_wr + 1 : 0;
            exp_st = h ? 0 : exp_wb + lat_rd + 2;
            access(rd, wr, a, wd, st, rdv, nr, nw, ra, wa, wdv);
            check("rand_stall", st, exp_st);
            check("rand_wb_cycles", nw, exp_wb);
            if (!wr) check("rand_rdata", rdv, flat[a]);
            if (!h) begin mv[ix] = 1; mt[ix] = tg; md[ix] = 0; end
            if (wr) begin flat[a] = wd; md[ix] = 1; end
        end

        // Every block not held dirty in the cache must match the reference in memory.
        bad = 0;
        for (int b = 0; b < 64; b++) begin
            if (!(mv[b % 8] && md[b % 8] && mt[b % 8] == 3'(b / 8)))
                if (backing[b] !== {flat[4*b+3], flat[4*b+2], flat[4*b+1], flat[4*b]}) bad++;
        end
        check("mem_coherent_blocks_bad", bad, 0);
        check("mem_read_write_overlap", both_hi, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/data_cache.md
# data_cache

Direct-mapped, write-back, write-allocate data cache between the CPU datapath and data memory. It sits directly downstream of the ALU: the ALU result is the byte address, and the register-file read operand is the store data. CPU stalls on `BUSYWAIT`; misses are serviced from a 32-bit-block data memory through a request/busywait handshake.

## Interface
- Parameters: none. Geometry is fixed at 8 blocks × 4 bytes (32 B) with an 8-bit byte address: tag [7:5], index [4:2], offset [1:0].
- `CLK` in 1: sole clock, rising edge.
- `RESET` in 1: synchronous, active-high.
- `READ` in 1: CPU load request.
- `WRITE` in 1: CPU store request.
- `ADDRESS` in 8: byte address from the ALU result.
- `WRITEDATA` in 8: store data from the register file.
- `READDATA` out 8: load data.
- `BUSYWAIT` out 1: CPU stall.
- `MEM_READ` out 1: memory block-read request.
- `MEM_WRITE` out 1: memory block-write request.
- `MEM_ADDRESS` out 6: block address {tag, index}.
- `MEM_WRITEDATA` out 32: block being written back.
- `MEM_READDATA` in 32: fetched block.
- `MEM_BUSYWAIT` in 1: memory busy.

## Operation
- Storage per block: valid bit, dirty bit, 3-bit tag, 32-bit data. Byte lane is little-endian: offset 0 maps to bits [7:0] and offset 3 to [31:24].
- Hit: `valid[idx]` is set and `tag[idx]` equals `ADDRESS[7:5]`. Hit is evaluated combinationally.
- State machine: IDLE, WRITEBACK, FETCH.
- **IDLE, read hit**
  - `READDATA` gives the selected byte combinationally.
  - `BUSYWAIT`=0.
- **IDLE, write hit**
  - The byte is written at the clock edge and dirty is set.
  - `BUSYWAIT`=0.
- **IDLE, miss (READ or WRITE)**
  - `BUSYWAIT`=1 combinationally.
  - Next state is WRITEBACK if the victim is valid and dirty, otherwise FETCH.
- **WRITEBACK**
  - Outputs: `MEM_WRITE`=1, `MEM_ADDRESS`={victim tag, idx}, `MEM_WRITEDATA`=victim block.
  - Exits to FETCH on the first edge where `MEM_BUSYWAIT`=0.
- **FETCH**
  - Outputs: `MEM_READ`=1, `MEM_ADDRESS`={`ADDRESS[7:5]`, idx}.
  - On the first edge where `MEM_BUSYWAIT`=0, the cache loads the block from `MEM_READDATA`, sets tag to `ADDRESS[7:5]`, valid=1, dirty=0, and returns to IDLE.
  - The access then completes as a hit: a write miss is allocated first and the byte is written on the following hit cycle.
- `BUSYWAIT`=1 in every cycle where (`READ`|`WRITE`) is high and the state is not IDLE-with-hit. `BUSYWAIT`=0 whenever neither request is active.
- `READ` and `WRITE` both high: treated as WRITE.
- The CPU holds `READ`, `WRITE`, `ADDRESS` and `WRITEDATA` stable while `BUSYWAIT`=1. Behaviour with changing inputs during a miss is undefined.
- Memory contract: memory drives `MEM_BUSYWAIT`=1 in the same cycle a request appears if it cannot complete at that edge. The cache holds the request, address and data stable until completion.
- Only one of `MEM_READ` and `MEM_WRITE` is ever asserted at a time.

## Timing
- Reset values, forced while `RESET`=1 and in effect from the edge after it is sampled:
  - State = IDLE.
  - All valid and dirty bits = 0. Tags and data are don't-care.
  - `MEM_READ`=`MEM_WRITE`=0.
  - `BUSYWAIT`=0 while `RESET` is high.
- Reset mid-miss: the memory transaction is abandoned, requests drop after the reset edge, and dirty data is lost.
- Hit latency: 0 stall cycles. Reads are combinational from `ADDRESS`; writes commit at the edge.
- Clean miss, memory latency L (edges with `MEM_BUSYWAIT`=1): stall = 1 (IDLE→FETCH) + L + 1 (FETCH completion) cycles. `BUSYWAIT` drops in the hit cycle after the refill.
- Dirty miss: adds L_wb + 1 cycles for WRITEBACK.
- `MEM_*` outputs are registered-state decodes and glitch-free across a state.

## Test plan
- **Reset then cold read**
  - Stimulus: reset, then READ at 0x00 with memory block 0 = 0xDDCCBBAA and latency 5.
  - Required: `MEM_READ` high with `MEM_ADDRESS`=0x00; `BUSYWAIT` high for 7 cycles; `READDATA`=0xAA. An immediate READ at 0x03 then returns 0xDD with `BUSYWAIT`=0.
- **Write hit**
  - Stimulus: after the above, WRITE 0x5A to 0x01, then READ 0x01.
  - Required: no stall and no memory activity; `READDATA`=0x5A; block 0 is dirty.
- **Dirty eviction**
  - Stimulus: READ at 0x20 (same index, tag 1).
  - Required: WRITEBACK with `MEM_ADDRESS`=0x00 and `MEM_WRITEDATA`=0xDDCC5AAA, then FETCH with `MEM_ADDRESS`=0x08; the stalled access then reads the fetched byte.
- **Write miss on a clean block**
  - Stimulus: WRITE 0x77 to 0x45.
  - Required: FETCH only with `MEM_ADDRESS`=0x11, no `MEM_WRITE`; afterwards READ 0x45 = 0x77 and block 1 is dirty.
- **Simultaneous READ and WRITE**
  - Stimulus: READ and WRITE high at 0x02 with data 0x11.
  - Required: treated as a write; a later read returns 0x11.
- **Reset mid-FETCH**
  - Stimulus: assert `RESET` during FETCH.
  - Required: `MEM_READ`=0 and `BUSYWAIT`=0 after the edge; the next READ to the same address misses again.
